// File: rtl/aes_pkg.sv
// AES shared constants: forward S-box table, state byte-position helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package aes_pkg;

  localparam int AES_STATE_W = 128;

  // Forward S-box. Element 0 is listed first.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // MSB bit position of row r, column c in the column-major 128-bit state.
  function automatic int byte_msb(input int r, input int c);
    return AES_STATE_W - 1 - 32 * c - 8 * r;
  endfunction

  // ShiftRows: output byte (r,c) is taken from input column (c+r) mod 4.
  function automatic int shift_src_col(input int r, input int c);
    return (c + r) % 4;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte.
// Latency: combinational.
// Backpressure: not applicable.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_sub_shift_stage.sv
// Registered SubBytes+ShiftRows of one AES round, sideband tag carried alongside.
// Latency: 1 clk from accept to out_valid when main reg empty; 1 block/clk throughput.
// Backpressure: main+skid regs; in_ready = ~skid valid (registered), no comb path from out_ready.
module aes_sub_shift_stage
  import aes_pkg::*;
#(
  parameter int TAG_W    = 8,
  parameter bit LAST_RND = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_last
);

  typedef struct packed {
    logic [AES_STATE_W-1:0] state;
    logic [TAG_W-1:0]       tag;
  } blk_t;

  logic [AES_STATE_W-1:0] sub_shift;
  blk_t                   new_blk;
  blk_t                   m_blk;
  blk_t                   s_blk;
  logic                   m_vld;
  logic                   s_vld;
  logic                   accept;
  logic                   m_free;

  // Transform sits ahead of the M/S mux so both registers capture finished data.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = byte_msb(r, c);
      localparam int SRC = byte_msb(r, shift_src_col(r, c));
      aes_sbox u_sbox (
        .in_byte  (in_state[SRC -: 8]),
        .out_byte (sub_shift[DST -: 8])
      );
    end
  end

  assign new_blk = '{state: sub_shift, tag: in_tag};

  // in_ready is gated low during reset so nothing is accepted into a clearing stage.
  assign in_ready  = ~s_vld & ~rst;
  assign accept    = in_valid & in_ready;
  assign m_free    = ~m_vld | out_ready;

  assign out_valid = m_vld;
  assign out_state = m_blk.state;
  assign out_tag   = m_blk.tag;
  assign out_last  = LAST_RND;

  // Main/skid control: refill M from S first (FIFO order), otherwise from input; overflow to S.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_blk <= '0;
      s_blk <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (m_free) begin
      if (s_vld) begin
        m_blk <= s_blk;
        m_vld <= 1'b1;
        s_vld <= 1'b0;
      end else if (accept) begin
        m_blk <= new_blk;
        m_vld <= 1'b1;
      end else begin
        m_vld <= 1'b0;
      end
    end else if (accept) begin
      s_blk <= new_blk;
      s_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_sub_shift_stage.sv
// Self-checking bench for aes_sub_shift_stage: directed vectors plus stall/flush/reset sequences.
// Latency: not applicable.
// Backpressure: out_ready driven by the bench.
module tb_aes_sub_shift_stage;

  typedef struct {
    logic [127:0] in_state;
    logic [127:0] exp_state;
  } vec_t;

  typedef struct {
    logic [127:0] state;
    logic [7:0]   tag;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [127:0] in_state;
  logic [7:0]   in_tag;
  logic         out_ready;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_state;
  logic [7:0]   out_tag;
  logic         out_last;
  logic         l_in_ready;
  logic         l_out_valid;
  logic [127:0] l_out_state;
  logic [7:0]   l_out_tag;
  logic         l_out_last;

  int n_chk;
  int n_fail;
  logic [7:0] sb [256];
  vec_t vecs [4];
  exp_t q [$];

  aes_sub_shift_stage #(.TAG_W(8), .LAST_RND(1'b0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_tag(out_tag), .out_last(out_last)
  );

  aes_sub_shift_stage #(.TAG_W(8), .LAST_RND(1'b1)) u_last (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(l_in_ready), .in_state(in_state), .in_tag(in_tag),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_state(l_out_state),
    .out_tag(l_out_tag), .out_last(l_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse (a^254) and the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, v[7:0]);
      b = inv;
      sb[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] mdl(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 32*c - 8*r -: 8] = sb[s[127 - 32*((c + r) % 4) - 8*r -: 8]];
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] a, b, c, cur_state;
    logic [7:0]   cur_tag;
    int sent, got, cyc;
    logic acc, take;

    n_chk = 0; n_fail = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_state = '0; in_tag = '0; out_ready = 1'b0;
    build_sbox();

    vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[1] = '{128'h00000000000000000000000000000000, 128'h63636363636363636363636363636363};
    vecs[2] = '{128'h53535353535353535353535353535353, 128'hedededededededededededededededed};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h636b6776f201ab7b30d777c5fe7c6f2b};

    // Reset state
    #12;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    chk("rst_out_tag", {120'd0, out_tag}, 128'd0);
    chk("rst_last_in_ready", {127'd0, l_in_ready}, 128'd0);
    @(posedge clk); #1 rst = 1'b0; #1;
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("out_last_0", {127'd0, out_last}, 128'd0);
    chk("out_last_1", {127'd0, l_out_last}, 128'd1);

    // Directed vectors, streamed back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_state = vecs[i].in_state; in_tag = 8'(i + 8'h40);
      tick();
      chk("vec_valid", {127'd0, out_valid}, 128'd1);
      chk("vec_state", out_state, vecs[i].exp_state);
      chk("vec_tag", {120'd0, out_tag}, {120'd0, 8'(i + 8'h40)});
      chk("vec_last_state", l_out_state, vecs[i].exp_state);
      chk("vec_last_vld_tag", {119'd0, l_out_valid, l_out_tag}, {119'd0, 1'b1, 8'(i + 8'h40)});
    end
    in_valid = 1'b0;
    tick();
    chk("vec_drain_valid", {127'd0, out_valid}, 128'd0);

    // Back-pressure: 3 blocks while stalled
    a = rnd128(); b = rnd128(); c = rnd128();
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = a; in_tag = 8'd1;
    tick();
    chk("bp1_in_ready", {127'd0, in_ready}, 128'd1);
    chk("bp1_tag", {120'd0, out_tag}, 128'd1);
    in_state = b; in_tag = 8'd2;
    tick();
    chk("bp2_in_ready", {127'd0, in_ready}, 128'd0);
    chk("bp2_state", out_state, mdl(a));
    in_state = c; in_tag = 8'd3;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bp_stall_ready", {127'd0, in_ready}, 128'd0);
      chk("bp_stall_state", out_state, mdl(a));
      chk("bp_stall_vld_tag", {119'd0, out_valid, out_tag}, {119'd0, 1'b1, 8'd1});
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel2_tag", {120'd0, out_tag}, 128'd2);
    chk("bp_rel2_state", out_state, mdl(b));
    chk("bp_rel2_in_ready", {127'd0, in_ready}, 128'd1);
    tick();
    chk("bp_rel3_tag", {120'd0, out_tag}, 128'd3);
    chk("bp_rel3_state", out_state, mdl(c));
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", {127'd0, out_valid}, 128'd0);

    // Streaming with random back-pressure against a scoreboard
    sent = 0; got = 0; cyc = 0;
    cur_state = rnd128(); cur_tag = 8'd0;
    while ((sent < 64 || q.size() != 0) && cyc < 2000) begin
      in_valid  = (sent < 64);
      in_state  = cur_state;
      in_tag    = cur_tag;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("st_valid_occupancy", {127'd0, out_valid}, {127'd0, q.size() != 0});
      if (out_valid && q.size() != 0) begin
        chk("st_state", out_state, q[0].state);
        chk("st_tag", {120'd0, out_tag}, {120'd0, q[0].tag});
      end
      acc  = in_valid & in_ready;
      take = out_valid & out_ready;
      if (take && q.size() != 0) begin
        void'(q.pop_front());
        got++;
      end
      if (acc) begin
        q.push_back('{mdl(cur_state), cur_tag});
        sent++;
        cur_state = rnd128();
        cur_tag = cur_tag + 8'd1;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("st_no_timeout", {127'd0, cyc < 2000}, 128'd1);
    chk("st_count", 128'(got), 128'd64);

    // flush with M and S full and an input presented
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = rnd128(); in_tag = 8'h11;
    tick();
    in_state = rnd128(); in_tag = 8'h12;
    tick();
    chk("fl_s_full", {127'd0, in_ready}, 128'd0);
    flush = 1'b1; in_state = rnd128(); in_tag = 8'h13;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {127'd0, out_valid}, 128'd0);
    chk("fl_in_ready", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_nothing_emitted", {127'd0, out_valid}, 128'd0);
    // flush with only M full: input is reported ready but discarded
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = rnd128(); in_tag = 8'h21;
    tick();
    flush = 1'b1; in_state = rnd128(); in_tag = 8'h22;
    #1;
    chk("fl2_in_ready", {127'd0, in_ready}, 128'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_valid", {127'd0, out_valid}, 128'd0);
    tick();
    chk("fl2_valid_later", {127'd0, out_valid}, 128'd0);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = rnd128(); in_tag = 8'h31;
    tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", {127'd0, out_valid}, 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {127'd0, out_valid}, 128'd0);
    chk("ar_state", out_state, 128'd0);
    chk("ar_tag", {120'd0, out_tag}, 128'd0);
    chk("ar_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk); #1 rst = 1'b0; #1;
    chk("ar_rel_in_ready", {127'd0, in_ready}, 128'd1);
    chk("ar_rel_valid", {127'd0, out_valid}, 128'd0);
    a = rnd128();
    in_valid = 1'b1; in_state = a; in_tag = 8'h32; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ar_next_vld_tag", {119'd0, out_valid, out_tag}, {119'd0, 1'b1, 8'h32});
    chk("ar_next_state", out_state, mdl(a));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
